// File: rtl/sevenseg_pkg.sv
// Shared seven-segment constants and decoder FSM states.
// Used by the display encoder and the receive-side decoder.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    WAIT_ANY,
    WAIT_OTHER,
    LOCKED
  } state_t;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam logic [3:0] DIGIT_ERR = 4'hE;

endpackage

// File: rtl/sevenseg_mux_decoder_seg7_to_digit.sv
// Combinational segment pattern {g,f,e,d,c,b,a} to digit lookup.
// Unknown patterns map to DIGIT_ERR and raise err.
module seg7_to_digit
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       err
);

  always_comb begin
    digit = DIGIT_ERR;
    err = 1'b0;
    case (seg)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: digit = DIGIT_BLANK;
      default: begin
        digit = DIGIT_ERR;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sevenseg_mux_decoder.sv
// Receive side of the muxed dual seven-segment bus: sync, debounce,
// decode and reassemble tens/ones, with stall detection.
module sevenseg_mux_decoder
  import sevenseg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYCLES = 2,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] code_in,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       frame_valid,
  output logic       locked,
  output logic       seg_err,
  output logic       stalled
);

  localparam logic [3:0] STB = 4'(STABLE_CYCLES);
  localparam logic [15:0] TO = 16'(TIMEOUT);

  logic [7:0] s;
  logic [7:0] p;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic armed;
  logic arm_nxt;
  logic [15:0] idle;
  state_t state;
  logic phase;
  logic changed;
  logic sel_edge;
  logic accept;
  logic timeout_hit;
  logic [3:0] digit;
  logic err;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = code_in;
    end else begin : g_sync
      logic [7:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= code_in;
          for (int i = 1; i < SYNC_STAGES; i++)
            sync_q[i] <= sync_q[i-1];
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  seg7_to_digit u_dec (
    .seg(s[6:0]),
    .digit(digit),
    .err(err)
  );

  assign changed = (s != p);
  assign sel_edge = s[7] ^ p[7];

  always_comb begin
    cnt_nxt = cnt;
    arm_nxt = armed;
    if (changed) begin
      cnt_nxt = 4'd1;
      arm_nxt = 1'b1;
    end else if (cnt != STB) begin
      cnt_nxt = cnt + 4'd1;
    end
  end

  assign accept = arm_nxt && (cnt_nxt == STB);
  assign timeout_hit = !sel_edge && (idle == TO - 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p <= '0;
      cnt <= '0;
      armed <= 1'b1;
      idle <= '0;
      state <= WAIT_ANY;
      phase <= 1'b0;
      tens <= DIGIT_BLANK;
      ones <= DIGIT_BLANK;
      frame_valid <= 1'b0;
      locked <= 1'b0;
      seg_err <= 1'b0;
      stalled <= 1'b0;
    end else begin
      p <= s;
      cnt <= cnt_nxt;
      armed <= arm_nxt & ~accept;
      frame_valid <= 1'b0;
      seg_err <= accept & err;
      if (sel_edge) idle <= '0;
      else if (idle != TO) idle <= idle + 16'd1;
      if (sel_edge) stalled <= 1'b0;
      else if (timeout_hit) stalled <= 1'b1;
      if (accept) begin
        if (s[7]) tens <= digit;
        else ones <= digit;
        phase <= s[7];
        unique case (state)
          WAIT_ANY: state <= WAIT_OTHER;
          WAIT_OTHER: begin
            if (s[7] != phase) begin
              state <= LOCKED;
              frame_valid <= 1'b1;
              locked <= 1'b1;
            end
          end
          LOCKED: begin
            if (s[7] != phase) begin
              frame_valid <= 1'b1;
            end else begin
              state <= WAIT_OTHER;
              locked <= 1'b0;
            end
          end
          default: state <= WAIT_ANY;
        endcase
      end
      // A stall forces a fresh resync even if a phase lands this cycle.
      if (timeout_hit) begin
        state <= WAIT_ANY;
        locked <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_mux_decoder.sv
// Directed bench for sevenseg_mux_decoder at default parameters.
module tb_sevenseg_mux_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] code_in = 8'h00;
  logic [3:0] tens;
  logic [3:0] ones;
  logic frame_valid;
  logic locked;
  logic seg_err;
  logic stalled;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  sevenseg_mux_decoder dut (
    .clk(clk),
    .reset(reset),
    .code_in(code_in),
    .tens(tens),
    .ones(ones),
    .frame_valid(frame_valid),
    .locked(locked),
    .seg_err(seg_err),
    .stalled(stalled)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    int sec;
    sec = 0;
    reset = 1'b1;
    code_in = 8'h00;
    repeat (3) tick();
    tests++;
    if (tens !== 4'hF) begin
      fails++; $display("FAIL reset_tens: got %h want f", tens);
    end
    tests++;
    if (ones !== 4'hF) begin
      fails++; $display("FAIL reset_ones: got %h want f", ones);
    end
    tests++;
    if ({frame_valid, locked, seg_err, stalled} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: got %b want 0000",
               {frame_valid, locked, seg_err, stalled});
    end
    reset = 1'b0;
    for (int e = 1; e <= 64; e++) begin
      tick();
      if (seg_err) sec++;
      if (e == 63) begin
        tests++;
        if (stalled !== 1'b0) begin
          fails++; $display("FAIL stall_early: got %b want 0", stalled);
        end
      end
      if (e == 64) begin
        tests++;
        if (stalled !== 1'b1) begin
          fails++; $display("FAIL stall_at_timeout: got %b want 1", stalled);
        end
      end
    end
    tests++;
    if (sec != 0) begin
      fails++; $display("FAIL idle_seg_err: got %0d want 0", sec);
    end
    tests++;
    if ({tens, ones} !== 8'hFF) begin
      fails++; $display("FAIL idle_digits: got %h want ff", {tens, ones});
    end
  endtask

  task automatic test_encoder_loop();
    int fvc, sec, last, gaps;
    fvc = 0; sec = 0; last = -1; gaps = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < 24) code_in = ((i / 2) % 2 == 0) ? 8'h86 : 8'h06;
      else code_in = 8'h06;
      tick();
      if (seg_err) sec++;
      if (frame_valid) begin
        if (last >= 0 && cyc - last != 2) gaps++;
        last = cyc;
        fvc++;
      end
    end
    tests++;
    if (fvc != 11) begin
      fails++; $display("FAIL loop_fv_count: got %0d want 11", fvc);
    end
    tests++;
    if (gaps != 0) begin
      fails++; $display("FAIL loop_fv_spacing: got %0d bad gaps want 0", gaps);
    end
    tests++;
    if (sec != 0) begin
      fails++; $display("FAIL loop_seg_err: got %0d want 0", sec);
    end
    tests++;
    if ({tens, ones} !== 8'h11) begin
      fails++; $display("FAIL loop_digits: got %h want 11", {tens, ones});
    end
    tests++;
    if ({locked, stalled} !== 2'b10) begin
      fails++;
      $display("FAIL loop_lock: got %b want 10", {locked, stalled});
    end
  endtask

  task automatic test_latency();
    int fvc;
    fvc = 0;
    code_in = 8'hBF;
    for (int e = 1; e <= 24; e++) begin
      tick();
      if (frame_valid) fvc++;
      if (e == 3) begin
        tests++;
        if (tens !== 4'h1) begin
          fails++; $display("FAIL lat_edge3: got %h want 1", tens);
        end
      end
      if (e == 4) begin
        tests++;
        if (tens !== 4'h0) begin
          fails++; $display("FAIL lat_edge4: got %h want 0", tens);
        end
      end
    end
    tests++;
    if (fvc != 1) begin
      fails++; $display("FAIL hold_single_accept: got %0d want 1", fvc);
    end
    tests++;
    if (locked !== 1'b1) begin
      fails++; $display("FAIL hold_locked: got %b want 1", locked);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] seq [4];
    int fvc, bad;
    seq[0] = 8'h06; seq[1] = 8'h7F; seq[2] = 8'h06; seq[3] = 8'h06;
    fvc = 0; bad = 0;
    for (int e = 1; e <= 14; e++) begin
      code_in = (e <= 4) ? seq[e-1] : 8'h06;
      tick();
      if (frame_valid) fvc++;
      if (ones == 4'h8) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL glitch_seen: got %0d cycles of 8 want 0", bad);
    end
    tests++;
    if (ones !== 4'h1) begin
      fails++; $display("FAIL glitch_ones: got %h want 1", ones);
    end
    tests++;
    if (fvc != 1) begin
      fails++; $display("FAIL glitch_fv: got %0d want 1", fvc);
    end
  endtask

  task automatic test_seg_err();
    int fvc, sec;
    fvc = 0; sec = 0;
    for (int e = 1; e <= 12; e++) begin
      code_in = (e <= 2) ? 8'h81 : 8'h06;
      tick();
      if (frame_valid) fvc++;
      if (seg_err) sec++;
    end
    tests++;
    if (tens !== 4'hE) begin
      fails++; $display("FAIL err_tens: got %h want e", tens);
    end
    tests++;
    if (sec != 1) begin
      fails++; $display("FAIL err_pulses: got %0d want 1", sec);
    end
    tests++;
    if (fvc != 2) begin
      fails++; $display("FAIL err_fv: got %0d want 2", fvc);
    end
  endtask

  task automatic test_resync();
    logic [7:0] bytes [5];
    logic fv_e, lk_e;
    int fvc;
    bytes[0] = 8'h86; bytes[1] = 8'h06; bytes[2] = 8'h5B;
    bytes[3] = 8'h4F; bytes[4] = 8'h86;
    for (int e = 1; e <= 13; e++) begin
      code_in = (e <= 10) ? bytes[(e-1)/2] : 8'h86;
      tick();
      fv_e = (e == 4 || e == 6 || e == 12);
      lk_e = (e < 8 || e > 11);
      tests++;
      if (frame_valid !== fv_e) begin
        fails++;
        $display("FAIL resync_fv e%0d: got %b want %b", e, frame_valid, fv_e);
      end
      tests++;
      if (locked !== lk_e) begin
        fails++;
        $display("FAIL resync_lock e%0d: got %b want %b", e, locked, lk_e);
      end
    end
    tests++;
    if ({tens, ones} !== 8'h13) begin
      fails++; $display("FAIL resync_digits: got %h want 13", {tens, ones});
    end
    code_in = 8'h06;
    tick();
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({tens, ones} !== 8'hFF) begin
      fails++; $display("FAIL midreset_digits: got %h want ff", {tens, ones});
    end
    tests++;
    if ({frame_valid, locked, seg_err, stalled} !== 4'b0000) begin
      fails++;
      $display("FAIL midreset_flags: got %b want 0000",
               {frame_valid, locked, seg_err, stalled});
    end
    tick();
    reset = 1'b0;
    fvc = 0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (frame_valid) fvc++;
    end
    tests++;
    if (fvc != 0) begin
      fails++; $display("FAIL post_reset_fv: got %0d want 0", fvc);
    end
    tests++;
    if (ones !== 4'h1) begin
      fails++; $display("FAIL post_reset_ones: got %h want 1", ones);
    end
  endtask

  initial begin
    test_reset();
    test_encoder_loop();
    test_latency();
    test_glitch();
    test_seg_err();
    test_resync();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
